// File: rtl/mips_boot_loader.sv
// Stream-fed program loader for the pipelined MIPS32 core: writes a header+payload
// image into unified memory, releases the core at the load base and waits for HLT.
module mips_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    output logic [ADDR_W-1:0] pc_init,
    input  logic              core_halted,
    output logic              run_done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        IDLE, HDR, LOAD, RELEASE, RUN, DONE, ERR
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    state_t              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                s_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                core_hold_q;
    logic                core_start_q;
    logic [ADDR_W-1:0]   pc_init_q;
    logic                run_done_q;
    logic                err_q;
    logic [ADDR_W:0]     wcnt_q;
    logic [31:0]         csum_q;
    logic                accept;

    assign accept = s_valid && s_ready_q;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            ptr_q        <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            core_start_q <= 1'b0;
            pc_init_q    <= '0;
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
            wcnt_q       <= '0;
            csum_q       <= '0;
        end else begin
            // Write strobe and release pulse are single-cycle unless re-armed below.
            mem_we_q     <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q   <= HDR;
                    s_ready_q <= 1'b1;
                end
                HDR: if (accept) begin
                    base_q <= s_data[ADDR_W-1:0];
                    ptr_q  <= s_data[ADDR_W-1:0];
                    wcnt_q <= '0;
                    csum_q <= '0;
                    if (s_last) begin
                        state_q      <= RELEASE;
                        s_ready_q    <= 1'b0;
                        core_start_q <= 1'b1;
                        pc_init_q    <= s_data[ADDR_W-1:0];
                    end else begin
                        state_q <= LOAD;
                    end
                end
                LOAD: if (accept) begin
                    // Overflow check wins over s_last: the extra word is never written.
                    if (wcnt_q == MAX_CNT) begin
                        state_q   <= ERR;
                        s_ready_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= s_data;
                        ptr_q       <= ptr_q + 1'b1;
                        wcnt_q      <= wcnt_q + 1'b1;
                        csum_q      <= csum_q + s_data;
                        if (s_last) begin
                            state_q      <= RELEASE;
                            s_ready_q    <= 1'b0;
                            core_start_q <= 1'b1;
                            pc_init_q    <= base_q;
                        end
                    end
                end
                RELEASE: begin
                    state_q     <= RUN;
                    core_hold_q <= 1'b0;
                end
                RUN: if (core_halted) begin
                    state_q     <= DONE;
                    core_hold_q <= 1'b1;
                    run_done_q  <= 1'b1;
                end
                DONE: if (start) begin
                    state_q    <= HDR;
                    s_ready_q  <= 1'b1;
                    run_done_q <= 1'b0;
                end
                ERR:     state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_hold    = core_hold_q;
    assign core_start   = core_start_q;
    assign pc_init      = pc_init_q;
    assign run_done     = run_done_q;
    assign err_overflow = err_q;
    assign word_count   = wcnt_q;
    assign checksum     = csum_q;

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Program loader sitting directly upstream of the pipelined MIPS32 core. It accepts a header-plus-payload word stream over a valid/ready handshake and writes the payload into the core's unified memory. It then releases the core with an initial PC and watches for HLT. This replaces bench-side memory preloading so that programs such as the factorial kernel can be booted from a stream source.

## Interface
- `ADDR_W`, 10: memory word-address width; addresses wrap modulo 2^ADDR_W.
- `MAX_WORDS`, 1024: maximum payload words per load, excluding the header.

Ports:
- `clk1`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE and DONE.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  32  stream word.
- `s_last`  in  1  marks the final word of a load.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  write data.
- `core_hold`  out  1  holds the core stalled (drives HALTED=1) while high.
- `core_start`  out  1  one-cycle pulse: core loads `pc_init`, clears HALTED and TAKEN_BRANCH.
- `pc_init`  out  ADDR_W  program entry address (= load base).
- `core_halted`  in  1  core has executed HLT.
- `run_done`  out  1  program has run to HLT.
- `err_overflow`  out  1  sticky payload-overflow error.
- `word_count`  out  ADDR_W+1  payload words written this load.
- `checksum`  out  32  wrapping 32-bit sum of payload words.

## Operation
- Reset values:
  - `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `core_hold`=1, `core_start`=0, `pc_init`=0.
  - `run_done`=0, `err_overflow`=0, `word_count`=0, `checksum`=0.
  - State = IDLE.
- Accept = `s_valid && s_ready`. `s_ready` is 1 only in HDR and LOAD.
- States:
  - IDLE: on `start` go to HDR.
  - HDR: the first accepted word is the header.
    - Store `base = s_data[ADDR_W-1:0]`; set the write pointer to `base`; clear `word_count` and `checksum`; go to LOAD.
    - If `s_last` is set on the header, the load is empty: go to RELEASE with `word_count`=0.
  - LOAD: each accepted word is written at the pointer.
    - The pointer then increments modulo 2^ADDR_W. `word_count` increments. `checksum` += word (mod 2^32).
    - An accept with `s_last` goes to RELEASE.
    - An accept when `word_count == MAX_WORDS` is dropped (no write): set `err_overflow`, go to ERR.
  - RELEASE (1 cycle): `core_start`=1, `pc_init`=base, `s_ready`=0; go to RUN.
  - RUN: `core_hold`=0; on `core_halted` go to DONE.
  - DONE: `run_done`=1, `core_hold`=1. On `start`, clear `run_done`, go to HDR.
  - ERR: `core_hold`=1, `s_ready`=0, `err_overflow`=1. Only `reset` exits.
- `core_hold`=1 in every state except RUN.
- `start` in HDR, LOAD, RELEASE, RUN or ERR is ignored.
- `core_halted` outside RUN is ignored.

## Timing
- Memory write is registered: accept at edge N gives `mem_we`=1 with addr/data stable during cycle N+1, for exactly one cycle per word.
  - Back-to-back accepts produce back-to-back writes; throughput is 1 word/cycle.
- The last payload accept at edge N:
  - the last write occurs in cycle N+1, coinciding with RELEASE and the `core_start` pulse;
  - `core_hold` falls at edge N+2.
- `checksum` and `word_count` update at the accept edge and are final from RELEASE onward.
- Reset mid-operation (any state): all outputs return to reset values immediately and the state returns to IDLE. A pending write is cancelled (`mem_we`=0 at once).
- Words presented while `s_ready`=0 are neither consumed nor written.

## Test plan
- Boot factorial: `start`, header 0, then 11 words `280a00c8`…`fc000000` with `s_last` on the 11th.
  - Required: writes to addr 0..10 in order, `word_count`=11, `core_start` one cycle with `pc_init`=0, `core_hold`=0 next cycle.
  - Drive `core_halted`=1: `run_done`=1 and `core_hold`=1 next cycle.
- Checksum wrap: header 200, words `FFFFFFFF` then `00000002` (last).
  - Required: mem[200]=`FFFFFFFF`, mem[201]=2, `checksum`=`00000001`.
- Address wrap and overflow:
  - With ADDR_W=4: header 15, 3 words. Required: writes at 15, 0, 1.
  - With MAX_WORDS=4: send 5 words. Required: 4 writes, 5th not written, `err_overflow`=1, state stays ERR until `reset`.
- Empty program: header 5 with `s_last`. Required: no `mem_we`, `core_start` with `pc_init`=5, `word_count`=0.
- Reset mid-load: after 2 of 6 words, pulse `reset` asynchronously. Required:
  - `mem_we`=0, `core_hold`=1, `s_ready`=0 immediately;
  - `start` before the reset-then-reload is ignored;
  - a subsequent full load succeeds from a clean count.
- Handshake: `s_valid` held high in IDLE yields no writes. `start` pulsed during LOAD has no effect. Random `s_valid` gaps still give one write per accept.
